prcoder_arbiter: RTL

- Sequential 8-requester arbiter that shares one resource, built around the team's priority-encoder function (highest set bit wins).
- Samples a request vector, picks a winner by fixed priority or rotating round-robin priority, and holds the grant until the owner releases.
- Outputs a one-hot grant plus the binary code of the owner, in the same 3-bit code format the priority encoder produces.

---
 rtl/prcoder_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prcoder_arbiter.sv
// 8-requester arbiter: fixed or round-robin priority, grant held until the owner releases.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module prcoder_arbiter #(
  parameter int unsigned N_REQ  = 8,
  parameter int unsigned CODE_W = 3
`ifdef ARB_TIMEOUT_EN
  ,parameter int unsigned MAX_HOLD = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              rr_mode,
  output logic [N_REQ-1:0]  gnt,
  output logic [CODE_W-1:0] gnt_code,
  output logic              gnt_valid,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    w_gnt_nxt;
  logic [CODE_W-1:0]   r_gnt_code;
  logic [CODE_W-1:0]   w_code_nxt;
  logic                r_gnt_valid;
  logic                w_valid_nxt;
  logic [CODE_W-1:0]   r_rr_ptr;
  logic [CODE_W-1:0]   w_ptr_nxt;
  logic [N_REQ-1:0]    w_rot;
  logic [CODE_W-1:0]   w_winner;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
`endif

  // Priority encoder: index of the highest set bit, 0 when empty.
  function automatic logic [CODE_W-1:0] prio_enc(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  // Round-robin: rotate right by rr_ptr, encode, then rotate the index back.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = req[CODE_W'(i) + r_rr_ptr];
    end
    if (rr_mode) w_winner = prio_enc(w_rot) + r_rr_ptr;
    else         w_winner = prio_enc(req);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_code_nxt  = r_gnt_code;
    w_valid_nxt = r_gnt_valid;
    w_ptr_nxt   = r_rr_ptr;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = N_REQ'(1) << w_winner;
          w_code_nxt  = w_winner;
          w_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_code]) begin
          w_state_nxt = S_RECOVER;
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_gnt_code;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          w_state_nxt   = S_RECOVER;
          w_gnt_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_gnt_code;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
`endif
      end
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_code  <= '0;
      r_gnt_valid <= 1'b0;
      r_rr_ptr    <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_code  <= w_code_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_rr_ptr    <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= w_hold_nxt;
      r_timeout   <= w_timeout_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_code  = r_gnt_code;
  assign gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule
